int_sequencer: RTL and testbench
================================

INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 Parameter JERRY, default 0; 0 = 5 sources (irq[4:0]), 1 = 6 sources (irq[5:0]).
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 reset_n  in  1  reset; asynchronous and active-low.
REQ-004 irq  in  6  interrupt sources, level; bit 5 ignored when JERRY=0.
REQ-005 atomic  in  1  pipeline in non-interruptible sequence; blocks injection start.
REQ-006 flagwr  in  1  one-cycle write strobe for control word.
REQ-007 wr_data  in  32  control word: [5:0] enable, [13:8] pending clear (W1C), [14] imask clear.
REQ-008 statrd  in  1  status read enable.
REQ-009 rd_data  out  32  status: [5:0] enable, [13:8] pending, [14] imask, [18:16] active level; 0 when statrd low.
REQ-010 ins_req  out  1  injected instruction valid.
REQ-011 ins  out  16  injected instruction word.
REQ-012 ins_ack  in  1  pipeline accepted ins this cycle.
REQ-013 imask  out  1  interrupt mask; high from first accepted word until cleared.
REQ-014 intser  out  1  high while sequence injection in progress.

Function
REQ-015 Pending bit n SHALL set on a 0->1 edge of irq[n] (one-cycle registered history), regardless of enable.
REQ-016 Pending bit n SHALL clear when flagwr with wr_data[8+n]=1; a simultaneous new edge wins (bit stays set).
REQ-017 Eligible = pending & enable; the highest eligible index wins arbitration (5 highest, 0 lowest).
REQ-018 States: IDLE, WAIT, INJECT, DONE.
REQ-019 IDLE -> WAIT when any eligible and imask=0; winning level latched into active level.
REQ-020 WAIT -> INJECT on first cycle atomic=0; WAIT holds while atomic=1.
REQ-021 INJECT: ins_req=1, ins = word[idx], idx 0..4; idx increments only on ins_ack; ins and idx stable while ins_ack=0.
REQ-022 Words 0,1,4 are fixed package constants; word 2 = VEC_LO | (level<<4); word 3 = VEC_HI.
REQ-023 On ack of word 0: imask<=1 and pending[level]<=0 in the same cycle.
REQ-024 On ack of word 4: INJECT -> DONE; DONE -> IDLE next cycle, ins_req=0 in DONE.
REQ-025 intser=1 in INJECT only.
REQ-026 flagwr with wr_data[14]=1 clears imask; ignored (imask stays 1) while in INJECT.
REQ-027 Arbitration is not re-evaluated after IDLE->WAIT; higher irq arriving in WAIT waits for next round.
REQ-028 If enable of the latched level is cleared while in WAIT, SHALL return to IDLE; in INJECT, sequence completes.
REQ-029 Enable bits update on flagwr; bit 5 reads 0 and is not writable when JERRY=0.
REQ-030 Injection latency: IDLE->first ins_req = 2 cycles when atomic=0.

Reset
REQ-031 reset_n low SHALL asynchronously force: state IDLE, idx 0, enable 0, pending 0, irq history 0, imask 0, active level 0, ins_req 0, ins 0, intser 0, rd_data 0.
REQ-032 Reset mid-INJECT abandons sequence; no further ins_req until a new eligible edge after release.

Structure
REQ-033 Shared package int_pkg: state enum, INT_WORD0/1/4, VEC_LO, VEC_HI, control/status bit positions.
REQ-034 One sub-module int_prio (6-bit priority encoder, output valid + 3-bit level); no others.

Verification
REQ-035 enable=0x3F, irq[2] edge, atomic=0, ins_ack=1 -> five words over 5 cycles, word2 = VEC_LO|0x20, imask=1, pending[2]=0.
REQ-036 irq[1] and irq[4] same cycle -> level 4 served; after imask clear, level 1 served.
REQ-037 atomic held 10 cycles -> state WAIT, ins_req=0 throughout; first word 1 cycle after atomic falls.
REQ-038 ins_ack low 3 cycles on word 1 -> ins holds word 1 unchanged; total sequence 8 cycles.
REQ-039 reset_n pulsed low during word 3 -> all outputs 0 immediately; no injection after release without new edge.
REQ-040 JERRY=0, irq[5] edge, write enable 0x3F -> rd_data[5]=0, rd_data[13]=0, no injection.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt sequencer.
package int_pkg;

  localparam int unsigned N_SRC  = 6;
  localparam int unsigned LVL_W  = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned INS_W  = 16;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd4;

  // Control word bit positions
  localparam int unsigned CTL_EN_LSB    = 0;
  localparam int unsigned CTL_CLR_LSB   = 8;
  localparam int unsigned CTL_IMCLR_BIT = 14;

  // Injected instruction words
  localparam logic [INS_W-1:0] INT_WORD0 = 16'h981E;
  localparam logic [INS_W-1:0] INT_WORD1 = 16'hD3A0;
  localparam logic [INS_W-1:0] INT_WORD4 = 16'h9818;
  localparam logic [INS_W-1:0] VEC_LO    = 16'h0A00;
  localparam logic [INS_W-1:0] VEC_HI    = 16'h00C3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_INJECT = 2'd2,
    ST_DONE   = 2'd3
  } int_state_e;

  // Status word layout as seen on rd_data
  typedef struct packed {
    logic [12:0]      rsvd_hi;
    logic [LVL_W-1:0] level;
    logic             rsvd_mid;
    logic             imask;
    logic [N_SRC-1:0] pending;
    logic [1:0]       rsvd_lo;
    logic [N_SRC-1:0] enable;
  } int_status_t;

  // Instruction word for a given sequence index; word 2 carries the level.
  function automatic logic [INS_W-1:0] int_word(input logic [IDX_W-1:0] idx,
                                                input logic [LVL_W-1:0] level);
    logic [INS_W-1:0] w;
    case (idx)
      3'd0:    w = INT_WORD0;
      3'd1:    w = INT_WORD1;
      3'd2:    w = VEC_LO | (INS_W'(level) << 4);
      3'd3:    w = VEC_HI;
      default: w = INT_WORD4;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/int_sequencer_if.sv
// Bus between the interrupt sequencer and the pipeline/register host.
interface int_sequencer_if;
  import int_pkg::*;

  logic [N_SRC-1:0]  irq;
  logic              atomic;
  logic              flagwr;
  logic [DATA_W-1:0] wr_data;
  logic              statrd;
  logic [DATA_W-1:0] rd_data;
  logic              ins_req;
  logic [INS_W-1:0]  ins;
  logic              ins_ack;
  logic              imask;
  logic              intser;

  modport master (
    output irq, atomic, flagwr, wr_data, statrd, ins_ack,
    input  rd_data, ins_req, ins, imask, intser
  );

  modport slave (
    input  irq, atomic, flagwr, wr_data, statrd, ins_ack,
    output rd_data, ins_req, ins, imask, intser
  );

endinterface

// File: rtl/int_prio.sv
// Priority encoder: highest set request bit wins.
module int_prio
  import int_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  output logic             valid_c,
  output logic [LVL_W-1:0] level_c
);

  // Scan upward so the last (highest) set bit overrides lower ones
  always_comb begin
    valid_c = |req;
    level_c = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[i]) level_c = LVL_W'(i);
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: latches irq edges, arbitrates, injects a 5-word sequence.
module int_sequencer
  import int_pkg::*;
#(
  parameter int unsigned JERRY = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  int_sequencer_if.slave  bus
);

  localparam logic [N_SRC-1:0] EN_MASK = (JERRY != 0) ? 6'h3F : 6'h1F;

  int_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [N_SRC-1:0]  hist_q, hist_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  enable_q, enable_d;
  logic              imask_q, imask_d;
  logic              ins_req_q, ins_req_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              intser_q, intser_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [N_SRC-1:0]  irq_c, edge_c, elig_c;
  logic              prio_valid_c;
  logic [LVL_W-1:0]  prio_level_c;
  logic              ack_c;
  int_status_t       status_c;
  logic              unused_wr_c;

  assign irq_c       = bus.irq & EN_MASK;
  assign edge_c      = irq_c & ~hist_q;
  assign elig_c      = pending_q & enable_q;
  assign ack_c       = (state_q == ST_INJECT) && bus.ins_ack;
  assign unused_wr_c = ^{bus.wr_data[31:15], bus.wr_data[7:6]};

  int_prio u_prio (
    .req     (elig_c),
    .valid_c (prio_valid_c),
    .level_c (prio_level_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      level_q   <= '0;
      hist_q    <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      imask_q   <= 1'b0;
      ins_req_q <= 1'b0;
      ins_q     <= '0;
      intser_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      level_q   <= level_d;
      hist_q    <= hist_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      imask_q   <= imask_d;
      ins_req_q <= ins_req_d;
      ins_q     <= ins_d;
      intser_q  <= intser_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next state, word index and latched level
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    level_d = level_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (prio_valid_c && !imask_q) begin
          state_d = ST_WAIT;
          level_d = prio_level_c;
        end
      end
      ST_WAIT: begin
        if (!enable_q[level_q]) begin
          state_d = ST_IDLE;
        end else if (!bus.atomic) begin
          state_d = ST_INJECT;
          idx_d   = '0;
        end
      end
      ST_INJECT: begin
        if (ack_c) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control/status registers and registered outputs
  always_comb begin
    hist_d    = irq_c;
    enable_d  = enable_q;
    pending_d = pending_q;
    imask_d   = imask_q;
    if (bus.flagwr) begin
      enable_d  = bus.wr_data[CTL_EN_LSB +: N_SRC] & EN_MASK;
      pending_d = pending_d & ~bus.wr_data[CTL_CLR_LSB +: N_SRC];
      if (bus.wr_data[CTL_IMCLR_BIT] && (state_q != ST_INJECT)) imask_d = 1'b0;
    end
    if (ack_c && (idx_q == '0)) begin
      imask_d            = 1'b1;
      pending_d[level_q] = 1'b0;
    end
    // A fresh edge always beats a clear in the same cycle
    pending_d = pending_d | edge_c;

    ins_req_d = (state_d == ST_INJECT);
    intser_d  = (state_d == ST_INJECT);
    ins_d     = ins_req_d ? int_word(idx_d, level_d) : '0;

    status_c         = '0;
    status_c.enable  = enable_q;
    status_c.pending = pending_q;
    status_c.imask   = imask_q;
    status_c.level   = level_q;
    rd_data_d        = bus.statrd ? DATA_W'(status_c) : '0;
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ins_req = ins_req_q;
  assign bus.ins     = ins_q;
  assign bus.imask   = imask_q;
  assign bus.intser  = intser_q;

endmodule

// File: tb/tb_int_sequencer.sv
// Scoreboard bench for int_sequencer (JERRY=0 build).
module tb_int_sequencer;
  import int_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic reset_n;

  int_sequencer_if bus ();

  int_sequencer #(.JERRY(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          intser_cnt = 0;
  logic [15:0] expq[$];
  chk_t        chkq[$];

  // Monitor: drains posted checks and scores every accepted instruction word
  always @(negedge clk) begin
    chk_t        c;
    logic [15:0] w;
    while (chkq.size() > 0) begin
      c = chkq.pop_front();
      n_cmp++;
      if (c.act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h, required %h", c.name, c.act, c.exp);
      end
    end
    if (reset_n && bus.ins_req && bus.ins_ack) begin
      n_cmp++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ins: got %h, required no injection", bus.ins);
      end else begin
        w = expq.pop_front();
        if (bus.ins !== w) begin
          n_err++;
          $display("FAIL ins_word: got %h, required %h", bus.ins, w);
        end
      end
    end
    if (bus.intser) intser_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chkq.push_back(c);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_ctl(input logic [31:0] d);
    bus.flagwr  = 1'b1;
    bus.wr_data = d;
    step(1);
    bus.flagwr  = 1'b0;
    bus.wr_data = '0;
  endtask

  task automatic read_stat(input string name, input logic [31:0] exp);
    bus.statrd = 1'b1;
    step(1);
    check(name, bus.rd_data, exp);
    bus.statrd = 1'b0;
  endtask

  task automatic push_seq(input logic [2:0] lvl);
    expq.push_back(INT_WORD0);
    expq.push_back(INT_WORD1);
    expq.push_back(VEC_LO | {9'd0, lvl, 4'd0});
    expq.push_back(VEC_HI);
    expq.push_back(INT_WORD4);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((expq.size() != 0 || bus.ins_req) && k < 60) begin
      step(1);
      k++;
    end
    check("wait_idle_left", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    int   c0;
    logic seen;
    reset_n     = 1'b0;
    bus.irq     = '0;
    bus.atomic  = 1'b0;
    bus.flagwr  = 1'b0;
    bus.wr_data = '0;
    bus.statrd  = 1'b0;
    bus.ins_ack = 1'b1;
    step(2);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_ins_req", 32'(bus.ins_req), 32'd0);
    check("rst_ins", 32'(bus.ins), 32'd0);
    check("rst_imask", 32'(bus.imask), 32'd0);
    check("rst_intser", 32'(bus.intser), 32'd0);
    reset_n = 1'b1;
    step(1);

    // Enable write masks bit 5 in the 5-source build
    write_ctl(32'h0000_003F);
    read_stat("enable_masked", 32'h0000_001F);
    step(1);
    check("rd_zero_no_statrd", bus.rd_data, 32'd0);

    // Single source, two-cycle latency, full sequence
    push_seq(3'd2);
    bus.irq = 6'h04;
    step(1);
    check("lat_cycle1_req", 32'(bus.ins_req), 32'd0);
    step(1);
    check("lat_cycle2_req", 32'(bus.ins_req), 32'd0);
    step(1);
    check("lat_first_req", 32'(bus.ins_req), 32'd1);
    check("lat_first_intser", 32'(bus.intser), 32'd1);
    check("lat_first_word", 32'(bus.ins), 32'(INT_WORD0));
    step(5);
    check("done_req_low", 32'(bus.ins_req), 32'd0);
    check("done_intser_low", 32'(bus.intser), 32'd0);
    check("done_imask_set", 32'(bus.imask), 32'd1);
    read_stat("lvl2_status", 32'h0002_401F);
    bus.irq = '0;
    write_ctl(32'h0000_403F);
    check("imask_cleared", 32'(bus.imask), 32'd0);

    // Two simultaneous sources: 4 first, 1 after imask clear
    push_seq(3'd4);
    bus.irq = 6'h12;
    wait_idle();
    check("lvl4_imask", 32'(bus.imask), 32'd1);
    step(5);
    read_stat("lvl1_still_pending", 32'h0004_421F);
    push_seq(3'd1);
    write_ctl(32'h0000_403F);
    wait_idle();
    bus.irq = '0;
    write_ctl(32'h0000_403F);

    // Atomic holds the sequence in WAIT
    push_seq(3'd3);
    bus.atomic = 1'b1;
    bus.irq    = 6'h08;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("atomic_hold_req", 32'(bus.ins_req), 32'd0);
    end
    bus.atomic = 1'b0;
    step(1);
    check("atomic_release_req", 32'(bus.ins_req), 32'd1);
    wait_idle();
    bus.irq = '0;
    write_ctl(32'h0000_403F);

    // Stalled acknowledge on word 1
    c0 = intser_cnt;
    push_seq(3'd0);
    bus.irq = 6'h01;
    step(3);
    check("stall_word0", 32'(bus.ins), 32'(INT_WORD0));
    step(1);
    check("stall_word1_a", 32'(bus.ins), 32'(INT_WORD1));
    bus.ins_ack = 1'b0;
    step(1);
    check("stall_word1_b", 32'(bus.ins), 32'(INT_WORD1));
    step(1);
    check("stall_word1_c", 32'(bus.ins), 32'(INT_WORD1));
    step(1);
    check("stall_word1_d", 32'(bus.ins), 32'(INT_WORD1));
    check("stall_req_held", 32'(bus.ins_req), 32'd1);
    bus.ins_ack = 1'b1;
    wait_idle();
    check("stall_seq_cycles", 32'(intser_cnt - c0), 32'd8);
    bus.irq = '0;
    write_ctl(32'h0000_403F);

    // Enable dropped while waiting aborts back to idle; then W1C pending
    bus.atomic = 1'b1;
    bus.irq    = 6'h02;
    step(3);
    write_ctl(32'h0000_003D);
    step(1);
    bus.atomic = 1'b0;
    step(5);
    check("abort_no_req", 32'(bus.ins_req), 32'd0);
    read_stat("abort_status", 32'h0001_021D);
    write_ctl(32'h0000_023D);
    read_stat("w1c_status", 32'h0001_001D);
    bus.irq = '0;
    write_ctl(32'h0000_003F);

    // Reset during word 3 abandons the sequence
    push_seq(3'd3);
    bus.irq = 6'h08;
    begin
      int k;
      k = 0;
      while (!(bus.ins_req && bus.ins == VEC_HI) && k < 30) begin
        step(1);
        k++;
      end
    end
    check("reached_word3", 32'(bus.ins), 32'(VEC_HI));
    #2 reset_n = 1'b0;
    #1;
    expq.delete();
    check("arst_ins_req", 32'(bus.ins_req), 32'd0);
    check("arst_ins", 32'(bus.ins), 32'd0);
    check("arst_imask", 32'(bus.imask), 32'd0);
    check("arst_intser", 32'(bus.intser), 32'd0);
    check("arst_rd_data", bus.rd_data, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      seen = seen | bus.ins_req;
    end
    check("no_inject_after_reset", 32'(seen), 32'd0);
    // irq[3] still high after release looks like a new edge, but enables are 0
    read_stat("status_after_reset", 32'h0000_0800);
    bus.irq = '0;

    // Source 5 ignored in the 5-source build
    write_ctl(32'h0000_083F);
    bus.irq = 6'h20;
    step(4);
    read_stat("src5_ignored", 32'h0000_001F);
    step(10);
    check("src5_no_req", 32'(bus.ins_req), 32'd0);
    check("final_queue_empty", 32'(expq.size()), 32'd0);
    bus.irq = '0;

    step(2);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
